// File: rtl/rv_pkg.sv
// rv_pkg -- shared processor package.
// Holds the default geometry of the integer register file and the helper
// that turns a register count into an address width.
package rv_pkg;

    localparam int XLEN_DEF  = 32;  // data width of one register
    localparam int NREGS_DEF = 32;  // architectural register count
    localparam int NRD_DEF   = 2;   // read ports
    localparam int NWR_DEF   = 2;   // write ports

    // Address width for a register count (ceil(log2(n))).
    function automatic int addr_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard -- one pending bit per register plus a registered count.
// A bit is set when a producer for that register issues and cleared when a
// write lands on it. Register 0 is never pending.
//   clk, reset : clock, asynchronous active-high reset
//   iss_en     : mark iss_addr pending at the next edge
//   iss_addr   : destination being issued
//   flush      : clear every pending bit at the next edge
//   wr_hit     : per-register "a write lands here this cycle"
//   pending    : current pending bits
//   pend_cnt   : population count of pending, updated with the bits
module reg_scoreboard import rv_pkg::*; #(
    parameter int  NREGS = NREGS_DEF,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic             flush,
    input  logic [NREGS-1:0] wr_hit,
    output logic [NREGS-1:0] pending,
    output logic [AW:0]      pend_cnt
);

    logic [NREGS-1:0] pend_nxt;
    logic [AW:0]      cnt_nxt;

    // Clear from writes first, then set from issue, so a producer issued in
    // the same cycle as an older write to its register stays pending.
    // Flush is applied last and overrides both.
    always_comb begin
        pend_nxt = pending & ~wr_hit;
        if (iss_en && iss_addr != '0) pend_nxt[iss_addr] = 1'b1;
        if (flush) pend_nxt = '0;
        pend_nxt[0] = 1'b0;
    end

    // Count is taken from the next-state bits so it tracks them exactly;
    // at most NREGS-1 bits can be set, which fits in AW+1 bits.
    always_comb begin
        cnt_nxt = '0;
        for (int r = 0; r < NREGS; r++) cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[r]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp -- multi-ported integer register file with write bypass and
// a pending-producer scoreboard.
//   clk, reset : clock, asynchronous active-high reset
//   rd_addr    : NRD read addresses, port i at [i*AW +: AW]
//   rd_data    : NRD read results (write data bypassed in the same cycle)
//   rd_ready   : per read port, operand is not waiting on a producer
//   wr_en/wr_addr/wr_data : NWR write ports, higher port wins on collision
//   iss_en/iss_addr : mark a destination pending
//   flush      : drop every pending bit
//   pend_cnt   : number of pending registers
module reg_file_mp import rv_pkg::*; #(
    parameter int  XLEN  = XLEN_DEF,
    parameter int  NREGS = NREGS_DEF,
    parameter int  NRD   = NRD_DEF,
    parameter int  NWR   = NWR_DEF,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_ready,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [AW:0]         pend_cnt
);

    logic [NRD-1:0][AW-1:0]     ra;
    logic [NRD-1:0][XLEN-1:0]   rd_q;
    logic [NWR-1:0][AW-1:0]     wa;
    logic [NWR-1:0][XLEN-1:0]   wd;

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           reg_we;   // register written this cycle
    logic [NREGS-1:0][XLEN-1:0] reg_wd;   // winning write data per register
    logic [NREGS-1:0]           pending;

    assign ra      = rd_addr;
    assign wa      = wr_addr;
    assign wd      = wr_data;
    assign rd_data = rd_q;

    // Per-register write resolution. Ports are scanned in ascending order so
    // the highest-numbered port hitting a register supplies its data. Entry 0
    // is skipped, which makes x0 unwritable and keeps it out of the bypass.
    always_comb begin
        reg_we = '0;
        reg_wd = '0;
        for (int r = 1; r < NREGS; r++) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wa[j] == AW'(r)) begin
                    reg_we[r] = 1'b1;
                    reg_wd[r] = wd[j];
                end
            end
        end
    end

    // Flop storage; reads are asynchronous so this must not map to RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++)
                if (reg_we[r]) regs[r] <= reg_wd[r];
        end
    end

    // Read ports: stored value, overridden by a same-cycle write, forced to
    // zero/ready for x0 and while reset is held.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [XLEN-1:0] d;
        logic            rdy;

        always_comb begin
            d   = regs[ra[i]];
            rdy = ~pending[ra[i]];
            if (reg_we[ra[i]]) begin
                d   = reg_wd[ra[i]];
                rdy = 1'b1;
            end
            if (ra[i] == '0 || reset) begin
                d   = '0;
                rdy = 1'b1;
            end
        end

        assign rd_q[i]     = d;
        assign rd_ready[i] = rdy;
    end

    reg_scoreboard #(
        .NREGS (NREGS)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .wr_hit   (reg_we),
        .pending  (pending),
        .pend_cnt (pend_cnt)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_ready;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;
    logic [AW:0]         pend_cnt;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .pend_cnt (pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        ie;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  ra0, ra1;
        logic [31:0] ed0, ed1;
        logic [1:0]  erdy;
        logic [5:0]  ecnt;
    } vec_t;

    // Reference state: architectural register values and the set of
    // registers waiting on a producer.
    logic [31:0] m_reg  [NREGS];
    bit          m_pend [NREGS];

    int nvec = 0;
    int nerr = 0;

    function automatic vec_t mk(input logic [1:0] we, input logic [4:0] wa0,
                                input logic [31:0] wd0, input logic [4:0] wa1,
                                input logic [31:0] wd1, input logic ie,
                                input logic [4:0] ia, input logic fl,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] ed0, input logic [31:0] ed1,
                                input logic [1:0] erdy, input logic [5:0] ecnt);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ie = ie; v.ia = ia; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
        v.ed0 = ed0; v.ed1 = ed1; v.erdy = erdy; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREGS; r++) begin
            m_reg[r]  = '0;
            m_pend[r] = 1'b0;
        end
    endtask

    // What a read of address a should see while vector v is applied.
    function automatic void m_read(input vec_t v, input logic [4:0] a,
                                   output logic [31:0] d, output logic r);
        d = m_reg[a];
        r = !m_pend[a];
        if (v.we[0] && v.wa0 == a) begin d = v.wd0; r = 1'b1; end
        if (v.we[1] && v.wa1 == a) begin d = v.wd1; r = 1'b1; end
        if (a == 0) begin d = '0; r = 1'b1; end
    endfunction

    function automatic int m_count();
        int c = 0;
        foreach (m_pend[r]) if (m_pend[r]) c++;
        return c;
    endfunction

    task automatic model_update(input vec_t v);
        if (v.we[0] && v.wa0 != 0) begin m_reg[v.wa0] = v.wd0; m_pend[v.wa0] = 1'b0; end
        if (v.we[1] && v.wa1 != 0) begin m_reg[v.wa1] = v.wd1; m_pend[v.wa1] = 1'b0; end
        if (v.ie && v.ia != 0) m_pend[v.ia] = 1'b1;
        if (v.fl) foreach (m_pend[r]) m_pend[r] = 1'b0;
    endtask

    // Entered just after a rising edge. Outputs are sampled on the falling
    // edge; expectations come from the vector (use_tbl) or the model.
    task automatic do_cycle(input vec_t v, input bit use_tbl);
        logic [31:0] e0, e1;
        logic        r0, r1;
        logic [5:0]  ec;
        wr_en    = v.we;
        wr_addr  = {v.wa1, v.wa0};
        wr_data  = {v.wd1, v.wd0};
        iss_en   = v.ie;
        iss_addr = v.ia;
        flush    = v.fl;
        rd_addr  = {v.ra1, v.ra0};
        @(negedge clk);
        m_read(v, v.ra0, e0, r0);
        m_read(v, v.ra1, e1, r1);
        ec = 6'(m_count());
        if (use_tbl) begin
            e0 = v.ed0; e1 = v.ed1; {r1, r0} = v.erdy; ec = v.ecnt;
        end
        check("rd_data0", rd_data[31:0], e0);
        check("rd_data1", rd_data[63:32], e1);
        check("rd_ready", {30'b0, rd_ready}, {30'b0, r1, r0});
        check("pend_cnt", {26'b0, pend_cnt}, {26'b0, ec});
        model_update(v);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    vec_t nop;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nop = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0);
        model_clear();

        // Reset state, with a write and issue presented that must be ignored.
        reset    = 1'b1;
        rd_addr  = {5'd7, 5'd5};
        wr_en    = 2'b01;
        wr_addr  = {5'd0, 5'd5};
        wr_data  = {32'h0, 32'h0000_FFFF};
        iss_en   = 1'b1;
        iss_addr = 5'd5;
        flush    = 1'b0;
        #2;
        check("reset_rd_data0", rd_data[31:0], 32'h0);
        check("reset_rd_data1", rd_data[63:32], 32'h0);
        check("reset_rd_ready", {30'b0, rd_ready}, 32'h3);
        check("reset_pend_cnt", {26'b0, pend_cnt}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed table: we, wa0, wd0, wa1, wd1, ie, ia, fl, ra0, ra1, ed0, ed1, erdy, ecnt
        tbl.push_back(mk(2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 2'b11, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 2'b11, 0));
        tbl.push_back(mk(2'b01, 0, 32'h1234, 0, 0, 1, 0, 0, 0, 5, 0, 32'hDEADBEEF, 2'b11, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0));
        tbl.push_back(mk(2'b11, 7, 32'hA, 7, 32'hB, 0, 0, 0, 7, 5, 32'hB, 32'hDEADBEEF, 2'b11, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 3, 0, 7, 3, 32'hB, 0, 2'b11, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 3, 7, 0, 32'hB, 2'b10, 1));
        tbl.push_back(mk(2'b10, 0, 0, 3, 32'h55, 0, 0, 0, 3, 3, 32'h55, 32'h55, 2'b11, 1));
        tbl.push_back(mk(2'b01, 9, 32'h99, 0, 0, 1, 9, 0, 3, 9, 32'h55, 32'h99, 2'b11, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 7, 32'h99, 32'hB, 2'b10, 1));
        foreach (tbl[k]) do_cycle(tbl[k], 1'b1);

        // Pend x1, x2, x4 on top of x9, then flush together with an issue.
        do_cycle(mk(2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b11, 0), 1'b0);
        do_cycle(mk(2'b00, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 2'b11, 0), 1'b0);
        do_cycle(mk(2'b00, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 2'b11, 0), 1'b0);
        do_cycle(mk(2'b00, 0, 0, 0, 0, 1, 10, 1, 10, 1, 0, 0, 2'b01, 4), 1'b1);
        do_cycle(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 10, 1, 0, 0, 2'b11, 0), 1'b1);

        // Reset in the middle of activity.
        do_cycle(mk(2'b01, 12, 32'hCAFE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0), 1'b0);
        do_cycle(mk(2'b00, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 2'b11, 0), 1'b0);
        do_cycle(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 12, 9, 32'hCAFE, 32'h99, 2'b10, 1), 1'b1);
        rd_addr  = {5'd7, 5'd12};
        wr_en    = 2'b11;
        wr_addr  = {5'd13, 5'd12};
        wr_data  = {32'h1313, 32'h1212};
        iss_en   = 1'b1;
        iss_addr = 5'd13;
        flush    = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midreset_rd_data0", rd_data[31:0], 32'h0);
        check("midreset_rd_data1", rd_data[63:32], 32'h0);
        check("midreset_rd_ready", {30'b0, rd_ready}, 32'h3);
        check("midreset_pend_cnt", {26'b0, pend_cnt}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        do_cycle(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 12, 13, 0, 0, 2'b11, 0), 1'b1);
        do_cycle(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 9, 0, 0, 2'b11, 0), 1'b1);

        // Random traffic against the model; narrow address ranges now and
        // then to force port collisions and issue/write overlap.
        for (int n = 0; n < 400; n++) begin
            vec_t v;
            int   amax;
            amax  = (n % 100 < 50) ? 7 : 31;
            v     = nop;
            v.we  = 2'($urandom_range(0, 3));
            v.wa0 = 5'($urandom_range(0, amax));
            v.wa1 = 5'($urandom_range(0, amax));
            v.wd0 = $urandom;
            v.wd1 = $urandom;
            v.ie  = ($urandom_range(0, 2) != 0);
            v.ia  = 5'($urandom_range(0, amax));
            v.fl  = ($urandom_range(0, 31) == 0);
            v.ra0 = 5'($urandom_range(0, amax));
            v.ra1 = 5'($urandom_range(0, amax));
            do_cycle(v, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the data width of each register.
REQ-002 SHALL have parameter NREGS, default 32, meaning the register count (power of 2, >=2); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, meaning the number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 2, meaning the number of write ports (1..2).
REQ-005 SHALL have port clk, input, 1 bit, the clock; rising edge active.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-007 SHALL have port rd_addr, input, NRD*AW bits, the read addresses (port i at bits [i*AW +: AW]).
REQ-008 SHALL have port rd_data, output, NRD*XLEN bits, the read data per port.
REQ-009 SHALL have port rd_ready, output, NRD bits, high when the port's operand is valid (not pending).
REQ-010 SHALL have port wr_en, input, NWR bits, the write enables per write port.
REQ-011 SHALL have port wr_addr, input, NWR*AW bits, the write addresses.
REQ-012 SHALL have port wr_data, input, NWR*XLEN bits, the write data.
REQ-013 SHALL have port iss_en, input, 1 bit, which marks the iss_addr register as pending (producer issued).
REQ-014 SHALL have port iss_addr, input, AW bits, the destination being issued.
REQ-015 SHALL have port flush, input, 1 bit, which clears all pending bits synchronously.
REQ-016 SHALL have port pend_cnt, output, AW+1 bits, the number of registers currently pending.

Function
REQ-017 SHALL commit each write at the rising clk edge when wr_en[j]=1 and wr_addr[j]!=0.
REQ-018 SHALL make register 0 read as zero, ignore writes to it, and never mark it pending.
REQ-019 SHALL resolve two write ports addressing the same register in one cycle in favour of port NWR-1, whose data is stored.
REQ-020 SHALL bypass reads combinationally: when rd_addr[i] matches an enabled, nonzero write address this cycle, rd_data[i] carries that write data (using the winning port per REQ-019); otherwise rd_data[i] carries the stored value.
REQ-021 SHALL hold one pending bit per register: set at the edge on iss_en (iss_addr!=0) and cleared at the edge by any enabled write to that register.
REQ-022 SHALL give set priority over clear when iss_en and a write target the same register in the same cycle (the new producer wins).
REQ-023 SHALL make flush clear every pending bit at the edge, overriding iss_en in that cycle; register contents are unaffected.
REQ-024 SHALL drive rd_ready[i] = !pending[rd_addr[i]] OR (a write to rd_addr[i] is occurring this cycle); rd_ready is always 1 for address 0.
REQ-025 SHALL maintain pend_cnt as a registered population count of the pending bits; it is updated in the same edge as those bits, has range 0..NREGS-1, and never wraps.
REQ-026 SHALL support a maximum of one iss_en per cycle; re-issuing a register that is already pending leaves pend_cnt unchanged.

Reset
REQ-027 SHALL, while reset=1 (asynchronous), clear all registers to 0, all pending bits to 0, and pend_cnt to 0.
REQ-028 SHALL make rd_data equal 0 and rd_ready all ones during reset, independent of clk.
REQ-029 SHALL discard writes, issues and flush requests presented in the cycle in which reset deasserts (reset is sampled high at that edge).

Structure
REQ-030 SHALL place the defaults of XLEN, NREGS, NRD and NWR, together with the AW derivation function, in the shared processor package rv_pkg.
REQ-031 SHALL implement the pending bits and pend_cnt in a single sub-module, reg_scoreboard; storage, bypass and read muxing stay in the top module.
REQ-032 SHALL build the storage from flops (no inferred RAM), because reads are asynchronous.

Verification
REQ-033 SHALL include a directed test: reset, then write 0xDEADBEEF to x5 via port 0, then read x5 on port 1 the next cycle -> rd_data=0xDEADBEEF, rd_ready=1.
REQ-034 SHALL include a directed test: write 0x1234 to x0 -> a read of x0 returns 0, and pend_cnt stays 0 after iss_en to x0.
REQ-035 SHALL include a directed test: both ports write x7 (0xA, 0xB) in the same cycle -> x7=0xB, and a read of x7 during that cycle bypasses 0xB.
REQ-036 SHALL include a directed test: iss_en x3 -> rd_ready=0 for x3 and pend_cnt=1; write x3 with 0x55 -> ready high in the write cycle (bypass 0x55), and pend_cnt=0 after the edge.
REQ-037 SHALL include a directed test: iss_en x9 together with a write to x9 in the same cycle -> x9 pending afterwards, data stored, and pend_cnt=1.
REQ-038 SHALL include a directed test: pend 4 registers, assert flush with iss_en x10 in the same cycle -> pend_cnt=0; separately, assert reset mid-sequence -> all state is cleared immediately.
